// File: rtl/trap_controller.sv
`default_nettype none
// ============================================================================
// Module   : trap_controller
// Purpose  : Machine-mode trap entry / MRET sequencer. At an instruction
//            boundary it picks the winning exception, MRET or interrupt,
//            holds the core, pulses the CSR update and redirects fetch.
// Revision : 1.0 - initial release
// ============================================================================
module trap_controller #(
  parameter int FAST_IRQS   = 16,
  parameter bit VECTORED_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        mstatus_mie_i,
  input  logic [31:0] csr_mie_i,
  input  logic [31:0] csr_mip_i,
  input  logic [31:0] csr_mtvec_i,
  input  logic [31:0] csr_mepc_i,
  input  logic        insn_boundary_i,
  input  logic [31:0] pc_current_i,
  input  logic [31:0] pc_next_i,
  input  logic        exc_illegal_i,
  input  logic        exc_ecall_i,
  input  logic        exc_ebreak_i,
  input  logic [31:0] exc_tval_i,
  input  logic        mret_i,
  output logic        core_hold_o,
  output logic        trap_wr_o,
  output logic [31:0] trap_mepc_o,
  output logic [31:0] trap_mcause_o,
  output logic [31:0] trap_mtval_o,
  output logic        mstatus_enter_o,
  output logic        mstatus_exit_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  input  logic        redirect_ready_i
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SAVE     = 2'd1,
    RESTORE  = 2'd2,
    REDIRECT = 2'd3
  } state_e;

  // Implemented interrupt lines: MSI(3), MTI(7), MEI(11) plus the fast lines.
  localparam logic [31:0] C_FAST_MASK = ((32'd1 << FAST_IRQS) - 32'd1) << 16;
  localparam logic [31:0] C_IRQ_MASK  = 32'h0000_0888 | C_FAST_MASK;

  state_e      state_q;
  logic        core_hold_q;
  logic        trap_wr_q;
  logic [31:0] trap_mepc_q;
  logic [31:0] trap_mcause_q;
  logic [31:0] trap_mtval_q;
  logic        mstatus_enter_q;
  logic        mstatus_exit_q;
  logic        redirect_valid_q;
  logic [31:0] redirect_pc_q;

  logic [31:0] irq_pend_d;
  logic        irq_valid_d;
  logic [4:0]  irq_code_d;
  logic        exc_valid_d;
  logic [4:0]  exc_code_d;
  logic [31:0] exc_mtval_d;
  logic [31:0] trap_base_d;
  logic [31:0] trap_target_d;

  // Interrupt arbitration: fast lines lowest index first, then MTI, MSI, MEI on top.
  always_comb begin
    irq_pend_d  = csr_mie_i & csr_mip_i & C_IRQ_MASK;
    irq_valid_d = mstatus_mie_i && (|irq_pend_d);
    irq_code_d  = 5'd0;
    for (int i = FAST_IRQS - 1; i >= 0; i--) begin
      if (irq_pend_d[16 + i]) irq_code_d = 5'(16 + i);
    end
    if (irq_pend_d[7])  irq_code_d = 5'd7;
    if (irq_pend_d[3])  irq_code_d = 5'd3;
    if (irq_pend_d[11]) irq_code_d = 5'd11;
  end

  // Exception arbitration: illegal > ebreak > ecall, with the matching mtval.
  always_comb begin
    exc_valid_d = exc_illegal_i | exc_ebreak_i | exc_ecall_i;
    exc_code_d  = 5'd11;
    exc_mtval_d = 32'd0;
    if (exc_illegal_i) begin
      exc_code_d  = 5'd2;
      exc_mtval_d = exc_tval_i;
    end else if (exc_ebreak_i) begin
      exc_code_d  = 5'd3;
      exc_mtval_d = pc_current_i;
    end
  end

  // Handler address from mtvec; only interrupts use the vectored offset.
  always_comb begin
    trap_base_d   = {csr_mtvec_i[31:2], 2'b00};
    trap_target_d = trap_base_d;
    if (VECTORED_EN && (csr_mtvec_i[1:0] == 2'b01) && trap_mcause_q[31]) begin
      trap_target_d = trap_base_d + {25'd0, trap_mcause_q[4:0], 2'b00};
    end
  end

  // Sequencer with registered outputs; pulses default low every cycle.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q          <= IDLE;
      core_hold_q      <= 1'b0;
      trap_wr_q        <= 1'b0;
      trap_mepc_q      <= 32'd0;
      trap_mcause_q    <= 32'd0;
      trap_mtval_q     <= 32'd0;
      mstatus_enter_q  <= 1'b0;
      mstatus_exit_q   <= 1'b0;
      redirect_valid_q <= 1'b0;
      redirect_pc_q    <= 32'd0;
    end else begin
      trap_wr_q       <= 1'b0;
      mstatus_enter_q <= 1'b0;
      mstatus_exit_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (insn_boundary_i) begin
            if (exc_valid_d) begin
              trap_mepc_q     <= pc_current_i;
              trap_mcause_q   <= {27'd0, exc_code_d};
              trap_mtval_q    <= exc_mtval_d;
              trap_wr_q       <= 1'b1;
              mstatus_enter_q <= 1'b1;
              core_hold_q     <= 1'b1;
              state_q         <= SAVE;
            end else if (mret_i) begin
              // Pending interrupts wait for the next boundary after MIE is restored.
              redirect_pc_q  <= csr_mepc_i & 32'hFFFF_FFFC;
              mstatus_exit_q <= 1'b1;
              core_hold_q    <= 1'b1;
              state_q        <= RESTORE;
            end else if (irq_valid_d) begin
              trap_mepc_q     <= pc_next_i;
              trap_mcause_q   <= {1'b1, 26'd0, irq_code_d};
              trap_mtval_q    <= 32'd0;
              trap_wr_q       <= 1'b1;
              mstatus_enter_q <= 1'b1;
              core_hold_q     <= 1'b1;
              state_q         <= SAVE;
            end
          end
        end
        SAVE: begin
          redirect_pc_q    <= trap_target_d;
          redirect_valid_q <= 1'b1;
          state_q          <= REDIRECT;
        end
        RESTORE: begin
          redirect_valid_q <= 1'b1;
          state_q          <= REDIRECT;
        end
        REDIRECT: begin
          if (redirect_ready_i) begin
            redirect_valid_q <= 1'b0;
            core_hold_q      <= 1'b0;
            state_q          <= IDLE;
          end
        end
        default: begin
          redirect_valid_q <= 1'b0;
          core_hold_q      <= 1'b0;
          state_q          <= IDLE;
        end
      endcase
    end
  end

  assign core_hold_o      = core_hold_q;
  assign trap_wr_o        = trap_wr_q;
  assign trap_mepc_o      = trap_mepc_q;
  assign trap_mcause_o    = trap_mcause_q;
  assign trap_mtval_o     = trap_mtval_q;
  assign mstatus_enter_o  = mstatus_enter_q;
  assign mstatus_exit_o   = mstatus_exit_q;
  assign redirect_valid_o = redirect_valid_q;
  assign redirect_pc_o    = redirect_pc_q;

endmodule
`default_nettype wire
